window_gen_3x3: RTL and testbench



---
 rtl/window_gen_3x3.sv | 100 ++++++++++
 tb/tb_window_gen_3x3.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// Raster-to-3x3 window generator with two row line buffers.
// Emits one registered neighbourhood per interior input pixel.
module window_gen_3x3 #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 13,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             frame_done
);

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] top [3];
  logic [PIX_W-1:0] mid [3];
  logic [PIX_W-1:0] bot [3];
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] rd0;
  logic [PIX_W-1:0] rd1;
  logic             last_col;
  logic             last_row;
  logic             emit;

  assign rd0      = lb0[col];
  assign rd1      = lb1[col];
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign emit     = (row >= RW'(2)) && (col >= CW'(2));

  // Line buffers are never cleared; rows are rewritten before use.
  always_ff @(posedge clk) begin
    if (!reset && in_valid) begin
      lb0[col] <= rd1;
      lb1[col] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      top        <= '{default: '0};
      mid        <= '{default: '0};
      bot        <= '{default: '0};
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        top <= '{top[1], top[2], rd0};
        mid <= '{mid[1], mid[2], rd1};
        bot <= '{bot[1], bot[2], in_pixel};
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (emit) begin
          out_valid  <= 1'b1;
          out_row    <= row - RW'(1);
          out_col    <= col - CW'(1);
          frame_done <= last_row && last_col;
        end
      end
    end
  end

  assign p0 = top[0];
  assign p1 = top[1];
  assign p2 = top[2];
  assign p3 = mid[0];
  assign p4 = mid[1];
  assign p5 = mid[2];
  assign p6 = bot[0];
  assign p7 = bot[1];
  assign p8 = bot[2];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomised self-checking bench for window_gen_3x3.
// A whole-frame image array predicts every window.
module tb_window_gen_3x3;

  localparam int W = 64;
  localparam int H = 64;

  logic        clk = 0;
  logic        reset;
  logic        in_valid;
  logic [12:0] in_pixel;
  logic        out_valid;
  logic        frame_done;
  logic [12:0] p [9];
  logic [5:0]  out_row;
  logic [5:0]  out_col;

  window_gen_3x3 dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pixel(in_pixel),
    .out_valid(out_valid),
    .p0(p[0]), .p1(p[1]), .p2(p[2]),
    .p3(p[3]), .p4(p[4]), .p5(p[5]),
    .p6(p[6]), .p7(p[7]), .p8(p[8]),
    .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mr = 0;
  int mc = 0;
  int n_win = 0;
  int n_fd = 0;
  logic [12:0] img [H][W];
  logic [127:0] snap;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {p[0], p[1], p[2], p[3], p[4], p[5],
            p[6], p[7], p[8], out_row, out_col};
  endfunction

  task automatic step(input bit v, input logic [12:0] pix);
    bit ev;
    bit efd;
    in_valid = v;
    in_pixel = pix;
    @(posedge clk);
    #1;
    ev  = 0;
    efd = 0;
    if (v) begin
      img[mr][mc] = pix;
      ev  = (mr >= 2) && (mc >= 2);
      efd = ev && (mr == H - 1) && (mc == W - 1);
      if (ev) begin
        for (int k = 0; k < 9; k++)
          chk($sformatf("p%0d(%0d,%0d)", k, mr, mc),
              128'(p[k]),
              128'(img[mr - 2 + k / 3][mc - 2 + k % 3]));
        chk("out_row", 128'(out_row), 128'(mr - 1));
        chk("out_col", 128'(out_col), 128'(mc - 1));
        n_win++;
      end
      if (efd) n_fd++;
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end else begin
      chk("hold", outs(), snap);
    end
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("frame_done", 128'(frame_done), 128'(efd));
    snap = outs();
  endtask

  task automatic do_reset();
    reset    = 1;
    in_valid = 1;
    in_pixel = 13'h1abc;
    @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_fd", 128'(frame_done), 128'(0));
    chk("rst_outs", outs(), 128'(0));
    reset = 0;
    mr = 0;
    mc = 0;
    snap = outs();
  endtask

  // mode 0 ramp, 1 constant max, 2 random pixels
  task automatic frame(input int mode, input int idle_pct,
                       input int stop_after);
    logic [12:0] v;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r * W + c == stop_after) return;
        while ($urandom_range(99) < idle_pct)
          step(0, 13'($urandom));
        case (mode)
          0:       v = 13'(r * W + c);
          1:       v = 13'h1fff;
          default: v = 13'($urandom);
        endcase
        step(1, v);
      end
  endtask

  initial begin
    reset = 1;
    in_valid = 0;
    in_pixel = 0;
    repeat (2) @(posedge clk);
    do_reset();

    n_win = 0; n_fd = 0;
    frame(0, 0, -1);
    chk("win_cnt_ramp", 128'(n_win), 128'(3844));
    chk("fd_cnt_ramp", 128'(n_fd), 128'(1));
    chk("fd_p8", 128'(p[8]), 128'(4095));
    chk("fd_p4", 128'(p[4]), 128'(4030));

    n_win = 0; n_fd = 0;
    frame(0, 40, -1);
    chk("win_cnt_gaps", 128'(n_win), 128'(3844));

    n_win = 0; n_fd = 0;
    frame(0, 0, -1);
    frame(0, 0, -1);
    chk("win_cnt_b2b", 128'(n_win), 128'(7688));
    chk("fd_cnt_b2b", 128'(n_fd), 128'(2));

    frame(2, 20, 10 * W + 6);
    do_reset();
    n_win = 0; n_fd = 0;
    frame(1, 10, -1);
    chk("win_cnt_const", 128'(n_win), 128'(3844));
    chk("const_p0", 128'(p[0]), 128'(8191));

    n_win = 0; n_fd = 0;
    frame(2, 30, -1);
    chk("win_cnt_rand", 128'(n_win), 128'(3844));
    chk("fd_cnt_rand", 128'(n_fd), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
